store_manage_unit: RTL and testbench
====================================

Name: store_manage_unit

Overview:
- Parametrised successor of the single-channel store-management handshake.
- Accepts up to CHANNELS store-commit / fence requests per cycle from the commit stage and buffers them in an in-order queue.
- Issues them one at a time to the store subsystem.
- Sequences FENCE / FENCE.VMA / FENCE.I: drains the store buffer, issues the fence, then waits for completion before the next entry.

Parameters:
- CHANNELS, 2, commit lanes accepted per cycle (1..4).
- DEPTH, 8, queue entries; power of two, DEPTH >= CHANNELS.
- ITAG_W, 8, instruction tag width.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- in_valid_i  in  CHANNELS  per-lane request valid
- in_commit_i  in  CHANNELS  per-lane store-commit request
- in_fence_i  in  CHANNELS  per-lane FENCE
- in_fencevma_i  in  CHANNELS  per-lane FENCE.VMA
- in_fencei_i  in  CHANNELS  per-lane FENCE.I
- in_itag_i  in  CHANNELS*ITAG_W  per-lane itag; lane c at [c*ITAG_W +: ITAG_W]
- in_ready_o  out  1  group ready
- out_valid_o  out  1  request to store subsystem
- out_ready_i  in  1  store subsystem accepts
- out_commit_o, out_fence_o, out_fencevma_o, out_fencei_o  out  1 each  kind of issued entry
- out_itag_o  out  ITAG_W  itag of issued entry
- sb_empty_i  in  1  store buffer empty (registered by the store subsystem)
- fence_done_i  in  1  one-cycle pulse: issued fence completed
- occupancy_o  out  $clog2(DEPTH)+1  entries held
- busy_o  out  1  queue non-empty or FSM not IDLE

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high (srst_i).
- On reset: queue pointers and count = 0, FSM = IDLE, out_valid_o = 0, all out_* kind bits = 0, out_itag_o = 0, in_ready_o = 0 during the reset cycle, busy_o = 0.
- Reset mid-operation discards all entries, including a fence awaiting fence_done_i. A late fence_done_i is ignored.

Enqueue:
- in_ready_o = (DEPTH - count) >= CHANNELS, computed from the registered count only; a same-cycle pop is not credited.
- When in_ready_o is high, every lane with in_valid_i set is enqueued in ascending lane order. Gaps are compacted.
- Pushes = popcount(in_valid_i).
- Lane kind is priority-encoded: fencei > fencevma > fence > commit. A valid lane with no kind bit set is enqueued as commit.
- Entry = {kind[1:0], itag}. Kind encoding goes in the package.

Count and pointers:
- count_next = count + pushes - pop. Simultaneous push and pop are legal.
- Pointers wrap modulo DEPTH.

FSM (head entry):
- IDLE:
  - If the head is commit: out_valid_o = 1 combinationally from the head. Pop on out_valid_o & out_ready_i; stay IDLE.
  - If the head is any fence: go to DRAIN, with out_valid_o = 0.
- DRAIN: out_valid_o = 0 until sb_empty_i is sampled high, then go to ISSUE.
- ISSUE: out_valid_o = 1 with the fence kind and itag. On handshake, pop and go to WAIT_DONE.
- WAIT_DONE: out_valid_o = 0. On fence_done_i, return to IDLE.
  - A fence_done_i pulse arriving in the handshake cycle is ignored.
  - A fence_done_i pulse outside WAIT_DONE is ignored.
- While out_valid_o = 1 and out_ready_i = 0: payload holds stable and the FSM does not advance.
- Empty queue: out_valid_o = 0, FSM stays IDLE.
- Full queue: in_ready_o = 0; the input lanes must hold.
- Throughput: one commit per cycle when out_ready_i is high.
- Minimum fence latency from reaching the head to out_valid_o: 2 cycles (IDLE -> DRAIN -> ISSUE) when sb_empty_i is already high.

Decomposition:
- Shared package (store_manage_pkg): entry kind enum (KIND_COMMIT, KIND_FENCE, KIND_FENCEVMA, KIND_FENCEI), entry struct typedef, FSM state enum.
- One sub-module: sm_multi_push_fifo. Parametrised CHANNELS-wide compacting push, single pop, exposes count. The FSM and issue logic stay in the top.

Test Plan:
- CHANNELS=2, DEPTH=8, out_ready_i=1: push lanes {commit itag 3, commit itag 4} -> out_itag_o 3 then 4 on consecutive cycles; occupancy_o returns to 0.
- Push in_valid_i=2'b10 (lane1 commit, itag 9) -> a single entry enqueued; occupancy_o = 1; out_itag_o = 9.
- Push 7 commits with out_ready_i=0 -> in_ready_o drops to 0 at count 7 (free 1 < 2). Pop once with a simultaneous push attempt -> still no accept that cycle; accepted the next cycle.
- Queue {commit 1, fence 2}, sb_empty_i=0 for 5 cycles after commit 1 issues -> out_valid_o = 0 throughout. sb_empty_i=1 -> fence presented 1 cycle later with out_fence_o = 1.
- Fence issued, fence_done_i delayed 4 cycles, commit 5 queued behind -> commit 5 is not issued until the cycle after fence_done_i.
- Assert srst_i while in WAIT_DONE with 3 entries queued -> next cycle occupancy_o = 0, out_valid_o = 0, busy_o = 0. A subsequent fence_done_i has no effect.

Source files
------------

// File: rtl/store_manage_pkg.sv
// Shared types for the store-management unit: entry kinds, entry layout and
// issue FSM states.
package store_manage_pkg;

  typedef enum logic [1:0] {
    KIND_COMMIT   = 2'd0,
    KIND_FENCE    = 2'd1,
    KIND_FENCEVMA = 2'd2,
    KIND_FENCEI   = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned ENTRY_ITAG_W = 8;

  // Queue entry layout; the top packs {kind, itag} in this order for any ITAG_W.
  typedef struct packed {
    kind_e                   kind;
    logic [ENTRY_ITAG_W-1:0] itag;
  } entry_t;

  // A valid lane with no kind bit set is still a store commit.
  function automatic kind_e lane_kind(input logic commit, input logic fence,
                                      input logic fencevma, input logic fencei);
    kind_e k;
    if (fencei) begin
      k = KIND_FENCEI;
    end else if (fencevma) begin
      k = KIND_FENCEVMA;
    end else if (fence) begin
      k = KIND_FENCE;
    end else if (commit) begin
      k = KIND_COMMIT;
    end else begin
      k = KIND_COMMIT;
    end
    return k;
  endfunction

endpackage

// File: rtl/store_manage_unit_fifo.sv
// In-order queue with a CHANNELS-wide compacting push and a single pop.
module sm_multi_push_fifo #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned W        = 10
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         push_en_i,
  input  logic [CHANNELS-1:0]          push_valid_i,
  input  logic [CHANNELS*W-1:0]        push_data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pushes_s;
  logic [PTR_W-1:0] wr_idx_s;

  // Valid lanes land in consecutive slots from wr_ptr, skipping idle lanes.
  always_comb begin
    mem_d    = mem_q;
    pushes_s = {CNT_W{1'b0}};
    wr_idx_s = wr_ptr_q;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_idx_s = wr_ptr_q + pushes_s[PTR_W-1:0];
      if (push_en_i && push_valid_i[c]) begin
        mem_d[wr_idx_s] = push_data_i[c*W +: W];
        pushes_s        = pushes_s + CNT_W'(1'b1);
      end else begin
      end
    end
    wr_ptr_d = wr_ptr_q + pushes_s[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + pushes_s - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/store_manage_unit.sv
// Store-commit / fence sequencer: buffers up to CHANNELS requests per cycle and
// issues them in order, draining the store buffer before each fence.
module store_manage_unit
  import store_manage_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ITAG_W   = ENTRY_ITAG_W
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [CHANNELS-1:0]        in_valid_i,
  input  logic [CHANNELS-1:0]        in_commit_i,
  input  logic [CHANNELS-1:0]        in_fence_i,
  input  logic [CHANNELS-1:0]        in_fencevma_i,
  input  logic [CHANNELS-1:0]        in_fencei_i,
  input  logic [CHANNELS*ITAG_W-1:0] in_itag_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_commit_o,
  output logic                       out_fence_o,
  output logic                       out_fencevma_o,
  output logic                       out_fencei_o,
  output logic [ITAG_W-1:0]          out_itag_o,
  input  logic                       sb_empty_i,
  input  logic                       fence_done_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       busy_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ITAG_W + 2;

  logic [CHANNELS*ENT_W-1:0] push_data_s;
  logic [ENT_W-1:0]          head_s;
  logic [CNT_W-1:0]          count_s;
  logic [CNT_W-1:0]          free_s;
  logic                      empty_s;
  logic                      pop_s;
  logic                      out_valid_s;
  kind_e                     head_kind_s;
  logic [ITAG_W-1:0]         head_itag_s;
  state_e                    state_q, state_d;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      push_data_s[c*ENT_W +: ENT_W] = {lane_kind(in_commit_i[c], in_fence_i[c],
                                                 in_fencevma_i[c], in_fencei_i[c]),
                                       in_itag_i[c*ITAG_W +: ITAG_W]};
    end
  end

  // Readiness uses the registered count only, so a same-cycle pop never frees a slot.
  assign free_s     = CNT_W'(DEPTH) - count_s;
  assign in_ready_o = !srst_i && (free_s >= CNT_W'(CHANNELS));

  sm_multi_push_fifo #(
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH),
    .W        (ENT_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .push_en_i    (in_ready_o),
    .push_valid_i (in_valid_i),
    .push_data_i  (push_data_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .count_o      (count_s)
  );

  assign empty_s     = (count_s == {CNT_W{1'b0}});
  assign head_kind_s = kind_e'(head_s[ENT_W-1 -: 2]);
  assign head_itag_s = head_s[ITAG_W-1:0];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_s = 1'b0;
    pop_s       = 1'b0;
    if (srst_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (empty_s) begin
            state_d = ST_IDLE;
          end else if (head_kind_s == KIND_COMMIT) begin
            out_valid_s = 1'b1;
            pop_s       = out_ready_i;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sb_empty_i) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          out_valid_s = 1'b1;
          if (out_ready_i) begin
            pop_s   = 1'b1;
            state_d = ST_WAIT_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT_DONE: begin
          if (fence_done_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Payload is zero whenever nothing is offered, which also covers the reset cycle.
  always_comb begin
    out_valid_o    = out_valid_s;
    out_commit_o   = 1'b0;
    out_fence_o    = 1'b0;
    out_fencevma_o = 1'b0;
    out_fencei_o   = 1'b0;
    out_itag_o     = {ITAG_W{1'b0}};
    if (out_valid_s) begin
      out_commit_o   = (head_kind_s == KIND_COMMIT);
      out_fence_o    = (head_kind_s == KIND_FENCE);
      out_fencevma_o = (head_kind_s == KIND_FENCEVMA);
      out_fencei_o   = (head_kind_s == KIND_FENCEI);
      out_itag_o     = head_itag_s;
    end else begin
      out_itag_o = {ITAG_W{1'b0}};
    end
  end

  assign occupancy_o = count_s;
  assign busy_o      = !srst_i && (!empty_s || (state_q != ST_IDLE));

endmodule

// File: tb/tb_store_manage_unit.sv
// Directed and randomized bench for store_manage_unit against a queue-based
// reference model of the issue rules.
module tb_store_manage_unit;

  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int IW    = 8;

  logic            clk_i = 1'b0;
  logic            srst_i;
  logic [CH-1:0]   in_valid_i, in_commit_i, in_fence_i, in_fencevma_i, in_fencei_i;
  logic [CH*IW-1:0] in_itag_i;
  logic            in_ready_o, out_valid_o, out_ready_i;
  logic            out_commit_o, out_fence_o, out_fencevma_o, out_fencei_o;
  logic [IW-1:0]   out_itag_o;
  logic            sb_empty_i, fence_done_i;
  logic [3:0]      occupancy_o;
  logic            busy_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int itag;
  } ent_t;

  ent_t mq[$];
  bit   m_seen;
  bit   m_ready;
  bit   m_wait;

  always #5 clk_i = ~clk_i;

  store_manage_unit #(.CHANNELS(CH), .DEPTH(DEPTH), .ITAG_W(IW)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .in_valid_i     (in_valid_i),
    .in_commit_i    (in_commit_i),
    .in_fence_i     (in_fence_i),
    .in_fencevma_i  (in_fencevma_i),
    .in_fencei_i    (in_fencei_i),
    .in_itag_i      (in_itag_i),
    .in_ready_o     (in_ready_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_commit_o   (out_commit_o),
    .out_fence_o    (out_fence_o),
    .out_fencevma_o (out_fencevma_o),
    .out_fencei_o   (out_fencei_o),
    .out_itag_o     (out_itag_o),
    .sb_empty_i     (sb_empty_i),
    .fence_done_i   (fence_done_i),
    .occupancy_o    (occupancy_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind numbering: 0 commit, 1 fence, 2 fence.vma, 3 fence.i
  function automatic int lane_kind_m(input int c);
    if (in_fencei_i[c]) return 3;
    if (in_fencevma_i[c]) return 2;
    if (in_fence_i[c]) return 1;
    return 0;
  endfunction

  task automatic clear_lanes();
    in_valid_i    = '0;
    in_commit_i   = '0;
    in_fence_i    = '0;
    in_fencevma_i = '0;
    in_fencei_i   = '0;
    in_itag_i     = '0;
  endtask

  task automatic set_lane(input int c, input int kind, input int itag);
    logic [31:0] t;
    t = itag;
    in_valid_i[c]          = 1'b1;
    in_commit_i[c]         = (kind == 0);
    in_fence_i[c]          = (kind == 1);
    in_fencevma_i[c]       = (kind == 2);
    in_fencei_i[c]         = (kind == 3);
    in_itag_i[c*IW +: IW]  = t[IW-1:0];
  endtask

  // Check outputs for the current inputs, advance the model, then step one clock.
  task automatic cycle();
    bit   e_ready, e_valid;
    ent_t e;
    logic [3:0] kinds;
    #1;
    kinds = {out_fencei_o, out_fencevma_o, out_fence_o, out_commit_o};
    if (srst_i) begin
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_kinds", kinds, 0);
      chk("rst_itag", out_itag_o, 0);
      mq.delete();
      m_seen  = 0;
      m_ready = 0;
      m_wait  = 0;
    end else begin
      e_ready = (DEPTH - mq.size()) >= CH;
      e_valid = !m_wait && (mq.size() > 0) && ((mq[0].kind == 0) || m_ready);
      chk("in_ready", in_ready_o, e_ready);
      chk("out_valid", out_valid_o, e_valid);
      chk("occupancy", occupancy_o, mq.size());
      chk("busy", busy_o, (mq.size() > 0) || m_seen || m_wait);
      if (e_valid) begin
        chk("out_kind", kinds, 32'd1 << mq[0].kind);
        chk("out_itag", out_itag_o, mq[0].itag);
      end
      if (m_wait) begin
        if (fence_done_i) m_wait = 0;
      end else if (mq.size() > 0) begin
        if (mq[0].kind == 0) begin
          if (out_ready_i) void'(mq.pop_front());
        end else if (!m_seen) begin
          m_seen = 1;
        end else if (!m_ready) begin
          if (sb_empty_i) m_ready = 1;
        end else if (out_ready_i) begin
          void'(mq.pop_front());
          m_seen  = 0;
          m_ready = 0;
          m_wait  = 1;
        end
      end
      if (e_ready) begin
        for (int c = 0; c < CH; c++) begin
          if (in_valid_i[c]) begin
            e.kind = lane_kind_m(c);
            e.itag = in_itag_i[c*IW +: IW];
            mq.push_back(e);
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clear_lanes();
    srst_i       = 1'b1;
    out_ready_i  = 1'b0;
    sb_empty_i   = 1'b1;
    fence_done_i = 1'b0;
    m_seen = 0; m_ready = 0; m_wait = 0;
    @(posedge clk_i);
    #1;
    cycle();
    cycle();
    srst_i = 1'b0;
    chk("reset_occupancy", occupancy_o, 0);
    chk("reset_valid", out_valid_o, 0);
    chk("reset_busy", busy_o, 0);

    // two commits in one group, issued back to back
    out_ready_i = 1'b1;
    set_lane(0, 0, 3);
    set_lane(1, 0, 4);
    cycle();
    clear_lanes();
    chk("pair_first_itag", out_itag_o, 3);
    cycle();
    chk("pair_second_itag", out_itag_o, 4);
    cycle();
    chk("pair_drained", occupancy_o, 0);

    // gap compaction: only lane 1 valid
    out_ready_i = 1'b0;
    set_lane(1, 0, 9);
    cycle();
    clear_lanes();
    chk("gap_occupancy", occupancy_o, 1);
    chk("gap_itag", out_itag_o, 9);
    out_ready_i = 1'b1;
    cycle();

    // fill to 7, then a pop is not credited in the same cycle
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 0, 10 + 2 * i);
      set_lane(1, 0, 11 + 2 * i);
      cycle();
    end
    clear_lanes();
    set_lane(0, 0, 16);
    cycle();
    clear_lanes();
    chk("full_ready_low", in_ready_o, 0);
    chk("full_occupancy", occupancy_o, 7);
    out_ready_i = 1'b1;
    set_lane(0, 0, 20);
    set_lane(1, 0, 21);
    cycle();
    chk("pop_not_credited", occupancy_o, 6);
    cycle();
    clear_lanes();
    chk("accepted_next", occupancy_o, 7);
    repeat (10) cycle();

    // fence waits for the store buffer to drain
    sb_empty_i = 1'b0;
    set_lane(0, 0, 1);
    set_lane(1, 1, 2);
    cycle();
    clear_lanes();
    chk("drain_commit_itag", out_itag_o, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("drain_hold", out_valid_o, 0);
      cycle();
    end
    sb_empty_i = 1'b1;
    cycle();
    chk("fence_presented", out_valid_o, 1);
    chk("fence_kind", out_fence_o, 1);
    chk("fence_itag", out_itag_o, 2);

    // commit behind the fence waits for fence_done
    set_lane(0, 0, 5);
    cycle();
    clear_lanes();
    for (int i = 0; i < 4; i++) begin
      chk("wait_done_hold", out_valid_o, 0);
      cycle();
    end
    fence_done_i = 1'b1;
    chk("wait_done_last", out_valid_o, 0);
    cycle();
    fence_done_i = 1'b0;
    chk("after_done_valid", out_valid_o, 1);
    chk("after_done_itag", out_itag_o, 5);
    cycle();

    // reset while waiting for fence completion with entries queued
    set_lane(0, 3, 6);
    cycle();
    clear_lanes();
    repeat (3) cycle();
    set_lane(0, 0, 7);
    set_lane(1, 0, 8);
    cycle();
    clear_lanes();
    set_lane(0, 0, 9);
    cycle();
    clear_lanes();
    chk("pre_reset_occupancy", occupancy_o, 3);
    chk("pre_reset_valid", out_valid_o, 0);
    chk("pre_reset_busy", busy_o, 1);
    srst_i = 1'b1;
    cycle();
    srst_i = 1'b0;
    chk("post_reset_occupancy", occupancy_o, 0);
    chk("post_reset_valid", out_valid_o, 0);
    chk("post_reset_busy", busy_o, 0);
    fence_done_i = 1'b1;
    cycle();
    fence_done_i = 1'b0;
    chk("late_done_busy", busy_o, 0);
    chk("late_done_valid", out_valid_o, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clear_lanes();
      for (int c = 0; c < CH; c++) begin
        in_valid_i[c]         = ($urandom_range(0, 2) != 0);
        in_commit_i[c]        = $urandom_range(0, 1);
        in_fence_i[c]         = ($urandom_range(0, 7) == 0);
        in_fencevma_i[c]      = ($urandom_range(0, 11) == 0);
        in_fencei_i[c]        = ($urandom_range(0, 15) == 0);
        in_itag_i[c*IW +: IW] = IW'($urandom);
      end
      out_ready_i  = ($urandom_range(0, 3) != 0);
      sb_empty_i   = $urandom_range(0, 1);
      fence_done_i = ($urandom_range(0, 5) == 0);
      srst_i       = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
